// File: rtl/diad_pkg.sv
// Shared definitions for the fetch front end: PC width, flush-counter width
// and the fetch_ctrl state encoding.
package diad_pkg;

    localparam int PC_W  = 12;
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        HALT  = 2'd3
    } fetch_state_t;

    function automatic logic [PC_W-1:0] pc_incr(input logic [PC_W-1:0] cur);
        return cur + PC_W'(1);
    endfunction

endpackage

// File: rtl/fetch_ctrl.sv
// Fetch controller: sequences the PC through boot, normal fetch, post-redirect
// bubbles and halt, and drives the fetch enable / flush / halted indications.
module fetch_ctrl
    import diad_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_VECTOR = 12'h000,
    parameter int              FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            branch_valid,
    input  logic [PC_W-1:0] branch_target,
    input  logic            halt_req,
    input  logic            resume,
    output logic [PC_W-1:0] pc,
    output logic            enable,
    output logic            flush,
    output logic            halted
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);

    fetch_state_t     state, state_nxt;
    logic [PC_W-1:0]  pc_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= BOOT;
            pc    <= RESET_VECTOR;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        cnt_nxt   = cnt;
        case (state)
            BOOT: state_nxt = RUN;
            RUN: begin
                // A redirect wins over both halt and stall.
                if (branch_valid) begin
                    pc_nxt    = branch_target;
                    cnt_nxt   = CNT_LOAD;
                    state_nxt = FLUSH;
                end else if (halt_req) begin
                    state_nxt = HALT;
                end else if (!stall) begin
                    pc_nxt = pc_incr(pc);
                end
            end
            FLUSH: begin
                if (branch_valid) begin
                    pc_nxt  = branch_target;
                    cnt_nxt = CNT_LOAD;
                end else if (cnt == '0) begin
                    state_nxt = RUN;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            HALT: begin
                if (branch_valid) pc_nxt = branch_target;
                if (resume)       state_nxt = RUN;
            end
            default: state_nxt = BOOT;
        endcase
    end

    assign enable = (state == RUN) && !stall;
    assign flush  = (state == FLUSH);
    assign halted = (state == HALT);

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_VECTOR, 12'h000, PC value loaded on reset.
REQ-002 Parameter FLUSH_CYCLES, 2, bubble cycles after a redirect; legal range 1..15.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 stall  input  1  downstream hold; freezes PC while in RUN.
REQ-006 branch_valid  input  1  one-cycle redirect request.
REQ-007 branch_target  input  12  redirect PC, sampled when branch_valid=1.
REQ-008 halt_req  input  1  level request to stop fetching.
REQ-009 resume  input  1  one-cycle request to leave HALT.
REQ-010 pc  output  12  registered PC driven to the instruction-address stage.
REQ-011 enable  output  1  fetch enable driven to the instruction-address stage.
REQ-012 flush  output  1  kill indication for in-flight fetch stages.
REQ-013 halted  output  1  high while in HALT.

Function
REQ-014 The FSM SHALL have four states: BOOT, RUN, FLUSH, HALT.
REQ-015 enable SHALL be combinational: (state==RUN) and not stall.
REQ-016 flush SHALL be 1 exactly while state==FLUSH; halted SHALL be 1 exactly while state==HALT.
REQ-017 BOOT SHALL last exactly one cycle, then go to RUN with pc unchanged.
REQ-018 RUN with branch_valid=1 SHALL load pc<=branch_target, load the flush counter with FLUSH_CYCLES-1, and go to FLUSH, regardless of stall or halt_req.
REQ-019 RUN with branch_valid=0 and halt_req=1 SHALL go to HALT with pc unchanged.
REQ-020 RUN with branch_valid=0, halt_req=0, stall=0 SHALL advance pc by 1 modulo 4096 (12'hFFF wraps to 12'h000).
REQ-021 RUN with stall=1 and no branch or halt SHALL hold pc and state.
REQ-022 FLUSH SHALL decrement the counter each cycle; on the cycle the counter is 0 it SHALL go to RUN, giving exactly FLUSH_CYCLES cycles with flush=1.
REQ-023 branch_valid in FLUSH SHALL load pc<=branch_target and reload the counter with FLUSH_CYCLES-1; the state SHALL remain FLUSH.
REQ-024 halt_req SHALL be ignored in FLUSH and acted on at the first RUN cycle where it is still high.
REQ-025 HALT with branch_valid=1 SHALL load pc<=branch_target without leaving HALT.
REQ-026 HALT with resume=1 SHALL go to RUN next cycle without a flush; branch_valid in the same cycle still loads pc.
REQ-027 resume SHALL be ignored outside HALT; stall SHALL be ignored outside RUN.
REQ-028 pc changes SHALL occur only on the transitions listed above.

Reset
REQ-029 Asserting rst SHALL immediately force state=BOOT, pc=RESET_VECTOR, flush counter=0, which gives enable=0, flush=0 and halted=0.
REQ-030 rst asserted mid-FLUSH or mid-HALT SHALL discard the pending counter or halt with no residual effect after release.

Structure
REQ-031 Shared package diad_pkg SHALL hold PC_W=12 and the fetch_ctrl state enum (BOOT, RUN, FLUSH, HALT).
REQ-032 No sub-module is required; the incrementer and flush counter SHALL be inline.

Verification
REQ-033 Reset release, stall=0 -> 1 BOOT cycle with enable=0, then pc 000,001,002 on successive cycles with enable=1.
REQ-034 pc=12'hFFE, run 3 cycles -> pc FFF, 000, 001.
REQ-035 branch_valid=1, target=12'h123, FLUSH_CYCLES=2 -> next cycle pc=123 and flush=1 for exactly 2 cycles with enable=0, then pc 124 in RUN.
REQ-036 Branch to 12'h200 followed 1 cycle later by a branch to 12'h300 during FLUSH -> pc=300 and flush extended to 2 cycles after the second branch.
REQ-037 halt_req=1 at pc=12'h010 -> HALT with halted=1 and pc held at 010; branch to 12'h050, then resume -> RUN at pc=050 with no flush, next pc 051.
REQ-038 rst pulsed during FLUSH -> pc=RESET_VECTOR and flush=0 immediately; BOOT then RUN sequence as in REQ-033.
